// File: rtl/arbiter_1_to_n_request_mc.sv
// 1-to-N memory-request demultiplexer with per-destination backpressure and multicast.
// A head packet is delivered to each addressed destination once, then retired.
module arbiter_1_to_n_request_mc #(
   parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
   parameter int unsigned FIFO_DEPTH           = 32,
   parameter int unsigned PROG_THRESH          = 16,
   parameter int unsigned ID_LEVEL             = 1,
   parameter int unsigned ID_BUNDLE            = 0,
   parameter bit          FORWARD_ENABLE       = 1'b1,
   parameter int unsigned DATA_W               = 32,
   localparam int unsigned N                   = NUM_MEMORY_REQUESTOR,
   localparam int unsigned PKT_W               = 5 * 32 + DATA_W
) (
   input  logic                      ap_clk,
   input  logic                      areset,
   input  logic                      request_in_valid,
   input  logic [31:0]               request_in_id_cu,
   input  logic [31:0]               request_in_id_bundle,
   input  logic [31:0]               request_in_id_lane,
   input  logic [31:0]               request_in_id_engine,
   input  logic [31:0]               request_in_id_module,
   input  logic [DATA_W-1:0]         request_in_data,
   input  logic [N-1:0]              fifo_request_signals_in_rd_en,
   output logic                      fifo_request_signals_out_full,
   output logic                      fifo_request_signals_out_empty,
   output logic                      fifo_request_signals_out_valid,
   output logic                      fifo_request_signals_out_prog_full,
   output logic                      fifo_request_signals_out_wr_rst_busy,
   output logic                      fifo_request_signals_out_rd_rst_busy,
   output logic [N-1:0]              request_out_valid,
   output logic [N-1:0][PKT_W-1:0]   request_out_payload,
   output logic                      fifo_setup_signal,
   output logic [15:0]               request_drop_count
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned CW       = AW + 1;
   localparam int unsigned RouteSel = (ID_LEVEL <= 4) ? ID_LEVEL : 0;
   localparam logic [N-1:0] OwnBundle = N'(1) << ID_BUNDLE;
   localparam logic [N-1:0] LastDest  = N'(1) << (N - 1);

   logic                  rst_q;
   logic                  in_valid_q;
   logic [PKT_W-1:0]      in_pkt_q;
   logic [N-1:0]          rdy_q;
   logic [PKT_W-1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         mem_cnt_q, mem_cnt_d, occ;
   logic                  head_valid_q, head_valid_d;
   logic [PKT_W-1:0]      head_q;
   logic [N-1:0]          served_q, served_d;
   logic [N-1:0]          out_valid_q;
   logic [PKT_W-1:0]      out_pkt_q [N];
   logic [15:0]           drop_q;
   logic [16:0]           drop_sum;
   logic                  setup_q;
   logic                  st_full_q, st_empty_q, st_valid_q, st_prog_full_q;

   logic [N-1:0]          dest, grant;
   logic                  full, pop, load, wr, route_drop, ovf_drop;

   // Payload layout: {id_module, id_engine, id_lane, id_bundle, id_cu, data}
   always_ff @(posedge ap_clk) begin
      rst_q <= areset;
      if (rst_q) begin
         in_valid_q <= 1'b0;
         in_pkt_q   <= '0;
         rdy_q      <= '0;
      end else begin
         in_valid_q <= request_in_valid;
         in_pkt_q   <= {request_in_id_module, request_in_id_engine, request_in_id_lane,
                        request_in_id_bundle, request_in_id_cu, request_in_data};
         rdy_q      <= fifo_request_signals_in_rd_en;
      end
   end

   always_comb begin
      dest = (ID_LEVEL == 5) ? '1 : head_q[DATA_W + 32 * RouteSel +: N];
      if (ID_LEVEL == 2 && FORWARD_ENABLE && head_q[DATA_W + 32 +: N] != OwnBundle) begin
         dest = LastDest;
      end
      grant      = dest & ~served_q & rdy_q;
      pop        = head_valid_q && ((served_q | grant) == dest);
      route_drop = head_valid_q && (dest == '0);
      occ        = mem_cnt_q + CW'(head_valid_q);
      full       = (occ == CW'(FIFO_DEPTH));
      // When full, a write only lands if the head retires in the same cycle.
      wr         = in_valid_q && (!full || pop);
      ovf_drop   = in_valid_q && full && !pop;
      load       = (!head_valid_q || pop) && (mem_cnt_q != '0);
      mem_cnt_d  = mem_cnt_q + CW'(wr) - CW'(load);
      head_valid_d = load ? 1'b1 : (pop ? 1'b0 : head_valid_q);
      served_d   = pop ? '0 : (head_valid_q ? (served_q | grant) : served_q);
      drop_sum   = {1'b0, drop_q} + 17'(route_drop) + 17'(ovf_drop);
   end

   always_ff @(posedge ap_clk) begin
      if (wr) mem[wr_ptr_q] <= in_pkt_q;
   end

   always_ff @(posedge ap_clk) begin
      if (rst_q) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_cnt_q    <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
         served_q     <= '0;
         out_valid_q  <= '0;
         drop_q       <= '0;
         for (int i = 0; i < int'(N); i++) out_pkt_q[i] <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_q + AW'(wr);
         rd_ptr_q     <= rd_ptr_q + AW'(load);
         mem_cnt_q    <= mem_cnt_d;
         head_valid_q <= head_valid_d;
         if (load) head_q <= mem[rd_ptr_q];
         served_q     <= served_d;
         out_valid_q  <= head_valid_q ? grant : '0;
         drop_q       <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (head_valid_q) begin
            for (int i = 0; i < int'(N); i++) out_pkt_q[i] <= head_q;
         end
      end
   end

   // Status is a registered view of the FIFO, one cycle behind.
   always_ff @(posedge ap_clk) begin
      setup_q <= rst_q;
      if (rst_q) begin
         st_full_q      <= 1'b0;
         st_empty_q     <= 1'b1;
         st_valid_q     <= 1'b0;
         st_prog_full_q <= 1'b0;
      end else begin
         st_full_q      <= full;
         st_empty_q     <= (occ == '0);
         st_valid_q     <= head_valid_q;
         st_prog_full_q <= (occ >= CW'(PROG_THRESH));
      end
   end

   always_comb begin
      for (int i = 0; i < int'(N); i++) request_out_payload[i] = out_pkt_q[i];
   end

   assign request_out_valid                    = out_valid_q;
   assign request_drop_count                   = drop_q;
   assign fifo_setup_signal                    = setup_q;
   assign fifo_request_signals_out_full        = st_full_q;
   assign fifo_request_signals_out_empty       = st_empty_q;
   assign fifo_request_signals_out_valid       = st_valid_q;
   assign fifo_request_signals_out_prog_full   = st_prog_full_q;
   assign fifo_request_signals_out_wr_rst_busy = setup_q;
   assign fifo_request_signals_out_rd_rst_busy = setup_q;

endmodule

// File: tb/tb_arbiter_1_to_n_request_mc.sv
// Bench for arbiter_1_to_n_request_mc: directed timing scenarios plus a randomized
// run scored against per-destination expected-delivery queues.
module tb_arbiter_1_to_n_request_mc;

   logic ap_clk = 1'b0;
   logic areset = 1'b1;
   always #5 ap_clk = ~ap_clk;

   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Instance A: N=4, routing on id_bundle
   logic              a_valid;
   logic [31:0]       a_id_cu, a_id_bundle, a_id_lane, a_id_engine, a_id_module, a_data;
   logic [3:0]        a_rd_en;
   logic              a_full, a_empty, a_fvalid, a_prog_full, a_wr_busy, a_rd_busy;
   logic [3:0]        a_out_valid;
   logic [3:0][191:0] a_out_payload;
   logic              a_setup;
   logic [15:0]       a_drop;

   // Instance B: N=4, routing on id_lane with bundle forwarding, own bundle 1
   logic              b_valid;
   logic [31:0]       b_id_cu, b_id_bundle, b_id_lane, b_id_engine, b_id_module, b_data;
   logic [3:0]        b_rd_en;
   logic              b_full, b_empty, b_fvalid, b_prog_full, b_wr_busy, b_rd_busy;
   logic [3:0]        b_out_valid;
   logic [3:0][191:0] b_out_payload;
   logic              b_setup;
   logic [15:0]       b_drop;

   arbiter_1_to_n_request_mc #(
      .NUM_MEMORY_REQUESTOR(4), .FIFO_DEPTH(32), .PROG_THRESH(16), .ID_LEVEL(1),
      .ID_BUNDLE(0), .FORWARD_ENABLE(1'b1), .DATA_W(32)
   ) dut_a (
      .ap_clk(ap_clk), .areset(areset), .request_in_valid(a_valid),
      .request_in_id_cu(a_id_cu), .request_in_id_bundle(a_id_bundle),
      .request_in_id_lane(a_id_lane), .request_in_id_engine(a_id_engine),
      .request_in_id_module(a_id_module), .request_in_data(a_data),
      .fifo_request_signals_in_rd_en(a_rd_en),
      .fifo_request_signals_out_full(a_full), .fifo_request_signals_out_empty(a_empty),
      .fifo_request_signals_out_valid(a_fvalid),
      .fifo_request_signals_out_prog_full(a_prog_full),
      .fifo_request_signals_out_wr_rst_busy(a_wr_busy),
      .fifo_request_signals_out_rd_rst_busy(a_rd_busy),
      .request_out_valid(a_out_valid), .request_out_payload(a_out_payload),
      .fifo_setup_signal(a_setup), .request_drop_count(a_drop)
   );

   arbiter_1_to_n_request_mc #(
      .NUM_MEMORY_REQUESTOR(4), .FIFO_DEPTH(32), .PROG_THRESH(16), .ID_LEVEL(2),
      .ID_BUNDLE(1), .FORWARD_ENABLE(1'b1), .DATA_W(32)
   ) dut_b (
      .ap_clk(ap_clk), .areset(areset), .request_in_valid(b_valid),
      .request_in_id_cu(b_id_cu), .request_in_id_bundle(b_id_bundle),
      .request_in_id_lane(b_id_lane), .request_in_id_engine(b_id_engine),
      .request_in_id_module(b_id_module), .request_in_data(b_data),
      .fifo_request_signals_in_rd_en(b_rd_en),
      .fifo_request_signals_out_full(b_full), .fifo_request_signals_out_empty(b_empty),
      .fifo_request_signals_out_valid(b_fvalid),
      .fifo_request_signals_out_prog_full(b_prog_full),
      .fifo_request_signals_out_wr_rst_busy(b_wr_busy),
      .fifo_request_signals_out_rd_rst_busy(b_rd_busy),
      .request_out_valid(b_out_valid), .request_out_payload(b_out_payload),
      .fifo_setup_signal(b_setup), .request_drop_count(b_drop)
   );

   logic [31:0] exp_q [4][$];

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [31:0] bundle, input logic [31:0] data);
      a_valid = v; a_id_bundle = bundle; a_data = data;
      a_id_cu = $urandom; a_id_lane = $urandom; a_id_engine = $urandom; a_id_module = $urandom;
   endtask

   task automatic drive_b(input logic v, input logic [31:0] bundle, input logic [31:0] lane,
                          input logic [31:0] data);
      b_valid = v; b_id_bundle = bundle; b_id_lane = lane; b_data = data;
      b_id_cu = $urandom; b_id_engine = $urandom; b_id_module = $urandom;
   endtask

   task automatic apply_reset();
      areset = 1'b1;
      repeat (3) tick();
      areset = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      repeat (4) tick();
      checks += 10;
      if (a_out_valid !== 4'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0000", a_out_valid); end
      if (b_out_valid !== 4'b0) begin errors++; $display("FAIL rst_b_out_valid got %b want 0000", b_out_valid); end
      if (a_drop !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", a_drop); end
      if (a_setup !== 1'b1) begin errors++; $display("FAIL rst_setup got %b want 1", a_setup); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", a_empty); end
      if (a_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", a_full); end
      if (a_prog_full !== 1'b0) begin errors++; $display("FAIL rst_prog_full got %b want 0", a_prog_full); end
      if (a_fvalid !== 1'b0) begin errors++; $display("FAIL rst_fvalid got %b want 0", a_fvalid); end
      if (a_wr_busy !== 1'b1) begin errors++; $display("FAIL rst_wr_busy got %b want 1", a_wr_busy); end
      if (a_rd_busy !== 1'b1) begin errors++; $display("FAIL rst_rd_busy got %b want 1", a_rd_busy); end
      areset = 1'b0;
      tick();
      checks++;
      if (a_setup !== 1'b1) begin errors++; $display("FAIL setup_hold1 got %b want 1", a_setup); end
      tick();
      checks += 2;
      if (a_setup !== 1'b0) begin errors++; $display("FAIL setup_release got %b want 0", a_setup); end
      if (a_rd_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_release got %b want 0", a_rd_busy); end
   endtask

   task automatic test_unicast();
      logic [31:0] dat [8];
      logic [3:0]  ev;
      for (int i = 0; i < 8; i++) dat[i] = $urandom;
      a_rd_en = 4'hF;
      tick(); tick();
      drive_a(1'b1, 32'h4, dat[0]);
      for (int step = 0; step < 14; step++) begin
         tick();
         ev = (step >= 3 && step <= 10) ? 4'b0100 : 4'b0000;
         checks++;
         if (a_out_valid !== ev) begin
            errors++; $display("FAIL uni_valid step %0d got %b want %b", step, a_out_valid, ev);
         end
         if (ev != 4'b0) begin
            checks++;
            if (a_out_payload[2][31:0] !== dat[step-3]) begin
               errors++;
               $display("FAIL uni_data step %0d got %h want %h", step, a_out_payload[2][31:0],
                        dat[step-3]);
            end
         end
         if (step < 7) drive_a(1'b1, 32'h4, dat[step+1]);
         else drive_a(1'b0, 32'h0, 32'h0);
      end
   endtask

   task automatic test_multicast();
      logic [31:0] d;
      logic [3:0]  ev;
      int          idx;
      d = $urandom;
      a_rd_en = 4'b0001;
      tick(); tick();
      drive_a(1'b1, 32'hB, d);
      for (int step = 0; step < 12; step++) begin
         tick();
         ev = (step == 3) ? 4'b0001 : (step == 5) ? 4'b0010 : (step == 7) ? 4'b1000 : 4'b0000;
         checks++;
         if (a_out_valid !== ev) begin
            errors++; $display("FAIL mc_valid step %0d got %b want %b", step, a_out_valid, ev);
         end
         if (ev != 4'b0) begin
            idx = (step == 3) ? 0 : (step == 5) ? 1 : 3;
            checks++;
            if (a_out_payload[idx][31:0] !== d) begin
               errors++; $display("FAIL mc_data out %0d got %h want %h", idx,
                                  a_out_payload[idx][31:0], d);
            end
         end
         if (step == 7) begin
            checks++;
            if (a_fvalid !== 1'b1) begin errors++; $display("FAIL mc_head_held got %b want 1", a_fvalid); end
         end
         if (step == 8) begin
            checks++;
            if (a_fvalid !== 1'b0) begin errors++; $display("FAIL mc_head_popped got %b want 0", a_fvalid); end
         end
         if (step == 0) drive_a(1'b0, 32'h0, 32'h0);
         if (step == 3) a_rd_en[1] = 1'b1;
         if (step == 5) a_rd_en[3] = 1'b1;
      end
      a_rd_en = 4'hF;
   endtask

   task automatic test_forward();
      logic [31:0] d0, d1;
      logic [3:0]  ev;
      d0 = $urandom; d1 = $urandom;
      b_rd_en = 4'hF;
      tick(); tick();
      drive_b(1'b1, 32'h4, 32'h3, d0);
      for (int step = 0; step < 8; step++) begin
         tick();
         ev = (step == 3) ? 4'b1000 : (step == 4) ? 4'b0101 : 4'b0000;
         checks++;
         if (b_out_valid !== ev) begin
            errors++; $display("FAIL fwd_valid step %0d got %b want %b", step, b_out_valid, ev);
         end
         if (step == 3) begin
            checks++;
            if (b_out_payload[3][31:0] !== d0) begin
               errors++; $display("FAIL fwd_data got %h want %h", b_out_payload[3][31:0], d0);
            end
         end
         if (step == 4) begin
            checks += 2;
            if (b_out_payload[0][31:0] !== d1) begin
               errors++; $display("FAIL lane_data0 got %h want %h", b_out_payload[0][31:0], d1);
            end
            if (b_out_payload[2][31:0] !== d1) begin
               errors++; $display("FAIL lane_data2 got %h want %h", b_out_payload[2][31:0], d1);
            end
         end
         if (step == 0) drive_b(1'b1, 32'h2, 32'h5, d1);
         else drive_b(1'b0, 32'h0, 32'h0, 32'h0);
      end
   endtask

   task automatic test_random();
      int          sent = 0;
      int          drops_exp = 0;
      logic [31:0] dm, dd;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      for (int c = 0; c < 130; c++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            if (a_out_valid[i] === 1'b1) begin
               checks++;
               if (exp_q[i].size() == 0) begin
                  errors++; $display("FAIL rnd_extra out %0d got %h want none", i,
                                     a_out_payload[i][31:0]);
               end else begin
                  dd = exp_q[i].pop_front();
                  if (a_out_payload[i][31:0] !== dd) begin
                     errors++; $display("FAIL rnd_data out %0d got %h want %h", i,
                                        a_out_payload[i][31:0], dd);
                  end
               end
            end
         end
         if (c < 60) begin
            a_rd_en = 4'($urandom_range(0, 15));
            if (sent < 20 && $urandom_range(0, 1) == 1) begin
               dm = 32'($urandom_range(0, 15));
               dd = $urandom;
               for (int i = 0; i < 4; i++) if (dm[i]) exp_q[i].push_back(dd);
               if (dm == 32'h0) drops_exp++;
               drive_a(1'b1, dm, dd);
               sent++;
            end else begin
               drive_a(1'b0, 32'h0, 32'h0);
            end
         end else begin
            a_rd_en = 4'hF;
            drive_a(1'b0, 32'h0, 32'h0);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (exp_q[i].size() != 0) begin
            errors++; $display("FAIL rnd_undelivered out %0d got %0d left want 0", i,
                               exp_q[i].size());
         end
      end
      checks++;
      if (a_drop !== 16'(drops_exp)) begin
         errors++; $display("FAIL rnd_drop got %0d want %0d", a_drop, drops_exp);
      end
   endtask

   task automatic test_overflow();
      int pf_step = -1;
      a_rd_en = 4'h0;
      drive_a(1'b0, 32'h0, 32'h0);
      apply_reset();
      drive_a(1'b1, 32'h0, $urandom);
      for (int step = 0; step < 51; step++) begin
         tick();
         if (a_prog_full === 1'b1 && pf_step < 0) pf_step = step;
         checks++;
         if (a_out_valid !== 4'b0) begin
            errors++; $display("FAIL ovf_no_out step %0d got %b want 0000", step, a_out_valid);
         end
         if (step < 40) drive_a(1'b1, 32'h1, $urandom);
         else drive_a(1'b0, 32'h0, 32'h0);
      end
      checks += 5;
      if (pf_step != 18) begin errors++; $display("FAIL ovf_prog_full_time got %0d want 18", pf_step); end
      if (a_drop !== 16'd9) begin errors++; $display("FAIL ovf_drop got %0d want 9", a_drop); end
      if (a_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", a_full); end
      if (a_prog_full !== 1'b1) begin errors++; $display("FAIL ovf_prog_full got %b want 1", a_prog_full); end
      if (a_empty !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", a_empty); end
   endtask

   task automatic test_reset_mid();
      a_rd_en = 4'hF;
      repeat (45) tick();
      checks++;
      if (a_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", a_empty); end
      a_rd_en = 4'b0001;
      tick(); tick();
      drive_a(1'b1, 32'hB, $urandom);
      for (int step = 0; step < 8; step++) begin
         tick();
         if (step == 0) drive_a(1'b0, 32'h0, 32'h0);
         if (step == 3) begin
            checks++;
            if (a_out_valid !== 4'b0001) begin
               errors++; $display("FAIL mid_first got %b want 0001", a_out_valid);
            end
         end
         if (step == 4) begin a_rd_en = 4'hF; areset = 1'b1; end
         if (step >= 6) begin
            checks += 5;
            if (a_out_valid !== 4'b0) begin errors++; $display("FAIL mid_out step %0d got %b want 0000", step, a_out_valid); end
            if (a_setup !== 1'b1) begin errors++; $display("FAIL mid_setup got %b want 1", a_setup); end
            if (a_drop !== 16'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", a_drop); end
            if (a_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", a_empty); end
            if (a_wr_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", a_wr_busy); end
         end
      end
      areset = 1'b0;
      for (int step = 0; step < 15; step++) begin
         tick();
         checks++;
         if (a_out_valid !== 4'b0) begin
            errors++; $display("FAIL stale_out step %0d got %b want 0000", step, a_out_valid);
         end
      end
      checks += 2;
      if (a_setup !== 1'b0) begin errors++; $display("FAIL post_setup got %b want 0", a_setup); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL post_empty got %b want 1", a_empty); end
   endtask

   initial begin
      a_rd_en = 4'h0;
      b_rd_en = 4'h0;
      drive_a(1'b0, 32'h0, 32'h0);
      drive_b(1'b0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_unicast();
      test_multicast();
      test_forward();
      test_random();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
